// File: rtl/urxd_byte_rx.sv
// UART 8N1 byte receiver: two-flop line synchronizer, 3-point majority bit sampling,
// good-byte and framing-error strobes, and an inter-byte idle-gap strobe.
module urxd_byte_rx #(
  parameter int unsigned F_CLK    = 50_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned GAP_BITS = 20
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       URXD,
  output logic       en_rx_byte,
  output logic       ok_rx_byte,
  output logic [7:0] dat,
  output logic       err_frm,
  output logic       ok_gap
);

  localparam int unsigned NT     = F_CLK / BAUD;
  localparam int unsigned H      = NT / 2;
  localparam int unsigned GapTot = GAP_BITS * NT;
  localparam int unsigned CW     = $clog2(NT);
  localparam int unsigned GW     = $clog2(GapTot + 1);

  localparam logic [CW-1:0] CntLast = CW'(NT - 1);
  localparam logic [CW-1:0] CntS0   = CW'(H - 1);
  localparam logic [CW-1:0] CntS1   = CW'(H);
  localparam logic [CW-1:0] CntDec  = CW'(H + 1);
  localparam logic [GW-1:0] GapLast = GW'(GapTot - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StStop   = 3'd3;
  localparam logic [2:0] StWaitHi = 3'd4;

  logic          sync_q, rxs_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    nbit_q, nbit_d;
  logic [1:0]    smp_q, smp_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    dat_q, dat_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic          gap_q, gap_d;
  logic          arm_q, arm_d;
  logic [GW-1:0] gcnt_q, gcnt_d;

  logic in_frame, wrap, decide, vote;

  assign in_frame = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
  assign wrap     = (cnt_q == CntLast);
  assign decide   = (cnt_q == CntDec);
  // Majority of the two earlier samples and the live sample at the decision edge.
  assign vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nbit_d  = nbit_q;
    smp_d   = smp_q;
    shreg_d = shreg_q;
    dat_d   = dat_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;

    if (in_frame) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
      if (wrap) nbit_d = nbit_q + 4'd1;
      if (cnt_q == CntS0) smp_d[0] = rxs_q;
      if (cnt_q == CntS1) smp_d[1] = rxs_q;
    end

    case (state_q)
      StIdle: begin
        if (!rxs_q) begin
          state_d = StStart;
          cnt_d   = '0;
          nbit_d  = 4'd0;
        end
      end
      StStart: begin
        if (decide && vote) begin
          state_d = StIdle;
        end else if (wrap) begin
          state_d = StData;
        end
      end
      StData: begin
        if (decide) shreg_d = {vote, shreg_q[7:1]};
        if (wrap && (nbit_q == 4'd8)) state_d = StStop;
      end
      StStop: begin
        // Leave at the decision so a back-to-back start bit is not missed.
        if (decide) begin
          if (vote) begin
            dat_d   = shreg_q;
            ok_d    = 1'b1;
            state_d = StIdle;
          end else begin
            err_d   = 1'b1;
            state_d = StWaitHi;
          end
        end
      end
      StWaitHi: begin
        if (rxs_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    arm_d  = arm_q;
    gcnt_d = gcnt_q;
    gap_d  = 1'b0;

    if (!rxs_q) begin
      gcnt_d = '0;
    end else if (arm_q && (state_q == StIdle)) begin
      if (gcnt_q == GapLast) begin
        gap_d  = 1'b1;
        arm_d  = 1'b0;
        gcnt_d = '0;
      end else begin
        gcnt_d = gcnt_q + GW'(1);
      end
    end

    if (ok_d) begin
      arm_d  = 1'b1;
      gcnt_d = '0;
    end
    if (err_d) arm_d = 1'b0;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sync_q  <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= StIdle;
      cnt_q   <= '0;
      nbit_q  <= 4'd0;
      smp_q   <= 2'b00;
      shreg_q <= 8'h00;
      dat_q   <= 8'h00;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      gap_q   <= 1'b0;
      arm_q   <= 1'b0;
      gcnt_q  <= '0;
    end else begin
      sync_q  <= URXD;
      rxs_q   <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nbit_q  <= nbit_d;
      smp_q   <= smp_d;
      shreg_q <= shreg_d;
      dat_q   <= dat_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
      arm_q   <= arm_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign en_rx_byte = in_frame;
  assign ok_rx_byte = ok_q;
  assign dat        = dat_q;
  assign err_frm    = err_q;
  assign ok_gap     = gap_q;

endmodule

// File: tb/tb_urxd_byte_rx.sv
// Bench for urxd_byte_rx: frames are built bit by bit from the byte value and strobe
// timing is predicted from the start-edge cycle; a negedge monitor logs every strobe.
module tb_urxd_byte_rx;

  localparam int NT   = 16;
  localparam int H    = 8;
  localparam int GAP  = 2;
  localparam int LAT  = 9 * NT + H + 2;
  localparam int MAXC = 16384;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       URXD = 1'b1;
  logic       en_rx_byte, ok_rx_byte, err_frm, ok_gap;
  logic [7:0] dat;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int         ok_cyc[$];
  logic [7:0] ok_dat[$];
  int         err_cyc[$];
  int         gap_cyc[$];
  int         all_cyc[$];
  logic       en_hist [0:MAXC-1];

  urxd_byte_rx #(
    .F_CLK   (16),
    .BAUD    (1),
    .GAP_BITS(GAP)
  ) u_dut (
    .clk       (clk),
    .res_n     (res_n),
    .URXD      (URXD),
    .en_rx_byte(en_rx_byte),
    .ok_rx_byte(ok_rx_byte),
    .dat       (dat),
    .err_frm   (err_frm),
    .ok_gap    (ok_gap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < MAXC) en_hist[cyc] = en_rx_byte;
    if (ok_rx_byte === 1'b1) begin
      ok_cyc.push_back(cyc);
      ok_dat.push_back(dat);
      all_cyc.push_back(cyc);
    end
    if (err_frm === 1'b1) begin
      err_cyc.push_back(cyc);
      all_cyc.push_back(cyc);
    end
    if (ok_gap === 1'b1) begin
      gap_cyc.push_back(cyc);
      all_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic clear_logs();
    ok_cyc.delete();
    ok_dat.delete();
    err_cyc.delete();
    gap_cyc.delete();
  endtask

  task automatic idle(input int n);
    URXD = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start edge leaves the line in this cycle; the receiver's E0 is 3 cycles on.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int spike_bit,
                            input int spike_off, output int e0);
    logic [9:0] bits;
    bits = {stop_v, b, 1'b0};
    e0 = cyc + 3;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < NT; k++) begin
        URXD = (i == spike_bit && k == spike_off) ? ~bits[i] : bits[i];
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (en_rx_byte !== 1'b0) begin $display("FAIL rst_en: got %b want 0", en_rx_byte); miscompares++; end
    vectors++; if (ok_rx_byte !== 1'b0) begin $display("FAIL rst_ok: got %b want 0", ok_rx_byte); miscompares++; end
    vectors++; if (dat !== 8'h00) begin $display("FAIL rst_dat: got %h want 00", dat); miscompares++; end
    vectors++; if (err_frm !== 1'b0) begin $display("FAIL rst_err: got %b want 0", err_frm); miscompares++; end
    vectors++; if (ok_gap !== 1'b0) begin $display("FAIL rst_gap: got %b want 0", ok_gap); miscompares++; end
    res_n = 1'b1;
    idle(5);
    vectors++; if (en_rx_byte !== 1'b0) begin $display("FAIL post_rst_en: got %b want 0", en_rx_byte); miscompares++; end
    vectors++; if (dat !== 8'h00) begin $display("FAIL post_rst_dat: got %h want 00", dat); miscompares++; end
  endtask

  task automatic test_single_byte();
    int e0;
    int es[$];
    logic [7:0] bs[$];
    logic [7:0] b;
    idle(10);
    clear_logs();
    send_frame(8'hA5, 1'b1, -1, 0, e0);
    idle(10);
    vectors++; if (ok_cyc.size() != 1) begin $display("FAIL a5_count: got %0d want 1", ok_cyc.size()); miscompares++; end
    if (ok_cyc.size() > 0) begin
      vectors++; if (ok_cyc[0] != e0 + LAT) begin $display("FAIL a5_cycle: got %0d want %0d", ok_cyc[0], e0 + LAT); miscompares++; end
      vectors++; if (ok_dat[0] !== 8'hA5) begin $display("FAIL a5_dat: got %h want a5", ok_dat[0]); miscompares++; end
    end
    vectors++; if (err_cyc.size() != 0) begin $display("FAIL a5_err: got %0d want 0", err_cyc.size()); miscompares++; end
    vectors++; if (en_hist[e0 - 1] !== 1'b0) begin $display("FAIL a5_en_pre: got %b want 0", en_hist[e0 - 1]); miscompares++; end
    vectors++; if (en_hist[e0] !== 1'b1) begin $display("FAIL a5_en_rise: got %b want 1", en_hist[e0]); miscompares++; end
    vectors++; if (en_hist[e0 + LAT - 1] !== 1'b1) begin $display("FAIL a5_en_last: got %b want 1", en_hist[e0 + LAT - 1]); miscompares++; end
    vectors++; if (en_hist[e0 + LAT] !== 1'b0) begin $display("FAIL a5_en_fall: got %b want 0", en_hist[e0 + LAT]); miscompares++; end

    clear_logs();
    for (int n = 0; n < 5; n++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, -1, 0, e0);
      es.push_back(e0);
      bs.push_back(b);
      idle($urandom_range(1, 20));
    end
    vectors++; if (ok_cyc.size() != 5) begin $display("FAIL rand_count: got %0d want 5", ok_cyc.size()); miscompares++; end
    for (int n = 0; n < 5 && n < ok_cyc.size(); n++) begin
      vectors++; if (ok_dat[n] !== bs[n]) begin $display("FAIL rand_dat%0d: got %h want %h", n, ok_dat[n], bs[n]); miscompares++; end
      vectors++; if (ok_cyc[n] != es[n] + LAT) begin $display("FAIL rand_cycle%0d: got %0d want %0d", n, ok_cyc[n], es[n] + LAT); miscompares++; end
    end
  endtask

  task automatic test_back_to_back();
    int e0a, e0b;
    idle(60);
    clear_logs();
    send_frame(8'h00, 1'b1, -1, 0, e0a);
    send_frame(8'hFF, 1'b1, -1, 0, e0b);
    idle(60);
    vectors++; if (ok_cyc.size() != 2) begin $display("FAIL b2b_count: got %0d want 2", ok_cyc.size()); miscompares++; end
    if (ok_cyc.size() == 2) begin
      vectors++; if (ok_dat[0] !== 8'h00) begin $display("FAIL b2b_dat0: got %h want 00", ok_dat[0]); miscompares++; end
      vectors++; if (ok_dat[1] !== 8'hFF) begin $display("FAIL b2b_dat1: got %h want ff", ok_dat[1]); miscompares++; end
      vectors++; if (ok_cyc[1] != e0b + LAT) begin $display("FAIL b2b_cycle1: got %0d want %0d", ok_cyc[1], e0b + LAT); miscompares++; end
    end
    vectors++; if (gap_cyc.size() != 1) begin $display("FAIL b2b_gap_count: got %0d want 1", gap_cyc.size()); miscompares++; end
    if (gap_cyc.size() > 0) begin
      vectors++; if (gap_cyc[0] != e0b + LAT + GAP * NT) begin $display("FAIL b2b_gap_cycle: got %0d want %0d", gap_cyc[0], e0b + LAT + GAP * NT); miscompares++; end
    end
    vectors++; if (err_cyc.size() != 0) begin $display("FAIL b2b_err: got %0d want 0", err_cyc.size()); miscompares++; end
  endtask

  task automatic test_glitch();
    int p, e0, bp;
    logic [7:0] b;
    idle(50);
    clear_logs();
    p = cyc;
    URXD = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    idle(40);
    vectors++; if (ok_cyc.size() + err_cyc.size() != 0) begin $display("FAIL glitch_strobe: got %0d want 0", ok_cyc.size() + err_cyc.size()); miscompares++; end
    vectors++; if (en_hist[p + 2] !== 1'b0) begin $display("FAIL glitch_en_pre: got %b want 0", en_hist[p + 2]); miscompares++; end
    vectors++; if (en_hist[p + 3 + H + 1] !== 1'b1) begin $display("FAIL glitch_en_hold: got %b want 1", en_hist[p + 3 + H + 1]); miscompares++; end
    vectors++; if (en_hist[p + 3 + H + 2] !== 1'b0) begin $display("FAIL glitch_en_drop: got %b want 0", en_hist[p + 3 + H + 2]); miscompares++; end

    for (int n = 0; n < 4; n++) begin
      clear_logs();
      b  = 8'($urandom);
      bp = $urandom_range(1, 8);
      send_frame(b, 1'b1, bp, H + 1, e0);
      idle(5);
      vectors++; if (ok_cyc.size() != 1) begin $display("FAIL spike_count%0d: got %0d want 1", n, ok_cyc.size()); miscompares++; end
      if (ok_cyc.size() > 0) begin
        vectors++; if (ok_dat[0] !== b) begin $display("FAIL spike_dat%0d: got %h want %h", n, ok_dat[0], b); miscompares++; end
      end
    end
  endtask

  task automatic test_frame_err();
    int e0a, e0b;
    logic [7:0] g;
    idle(60);
    clear_logs();
    g = 8'($urandom);
    send_frame(g, 1'b1, -1, 0, e0a);
    send_frame(8'h3C, 1'b0, -1, 0, e0b);
    URXD = 1'b0;
    repeat (100) begin
      @(posedge clk);
      #1;
    end
    idle(60);
    vectors++; if (ok_cyc.size() != 1) begin $display("FAIL ferr_ok_count: got %0d want 1", ok_cyc.size()); miscompares++; end
    vectors++; if (err_cyc.size() != 1) begin $display("FAIL ferr_count: got %0d want 1", err_cyc.size()); miscompares++; end
    if (err_cyc.size() > 0) begin
      vectors++; if (err_cyc[0] != e0b + LAT) begin $display("FAIL ferr_cycle: got %0d want %0d", err_cyc[0], e0b + LAT); miscompares++; end
    end
    vectors++; if (dat !== g) begin $display("FAIL ferr_dat_hold: got %h want %h", dat, g); miscompares++; end
    vectors++; if (gap_cyc.size() != 0) begin $display("FAIL ferr_gap: got %0d want 0", gap_cyc.size()); miscompares++; end
    vectors++; if (en_hist[e0b + LAT + 5] !== 1'b0) begin $display("FAIL ferr_en_wait: got %b want 0", en_hist[e0b + LAT + 5]); miscompares++; end

    clear_logs();
    send_frame(8'h5A, 1'b1, -1, 0, e0a);
    idle(5);
    vectors++; if (ok_cyc.size() != 1) begin $display("FAIL after_err_count: got %0d want 1", ok_cyc.size()); miscompares++; end
    if (ok_cyc.size() > 0) begin
      vectors++; if (ok_dat[0] !== 8'h5A) begin $display("FAIL after_err_dat: got %h want 5a", ok_dat[0]); miscompares++; end
      vectors++; if (ok_cyc[0] != e0a + LAT) begin $display("FAIL after_err_cycle: got %0d want %0d", ok_cyc[0], e0a + LAT); miscompares++; end
    end
    vectors++; if (err_cyc.size() != 0) begin $display("FAIL after_err_err: got %0d want 0", err_cyc.size()); miscompares++; end
  endtask

  task automatic test_reset_mid();
    int e0;
    int r;
    logic [7:0] b;
    logic [9:0] bits;
    idle(60);
    clear_logs();
    r = $urandom;
    b = {4'hF, r[3:0]};
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < NT; k++) begin
        URXD = bits[i];
        @(posedge clk);
        #1;
      end
    end
    URXD = 1'b1;
    vectors++; if (en_rx_byte !== 1'b1) begin $display("FAIL mid_en_busy: got %b want 1", en_rx_byte); miscompares++; end
    res_n = 1'b0;
    #2;
    vectors++; if (en_rx_byte !== 1'b0) begin $display("FAIL mid_rst_en: got %b want 0", en_rx_byte); miscompares++; end
    vectors++; if (dat !== 8'h00) begin $display("FAIL mid_rst_dat: got %h want 00", dat); miscompares++; end
    vectors++; if ({ok_rx_byte, err_frm, ok_gap} !== 3'b000) begin $display("FAIL mid_rst_strobes: got %b want 000", {ok_rx_byte, err_frm, ok_gap}); miscompares++; end
    repeat (2) @(posedge clk);
    #1;
    res_n = 1'b1;
    idle(90);
    vectors++; if (ok_cyc.size() + err_cyc.size() != 0) begin $display("FAIL mid_no_strobe: got %0d want 0", ok_cyc.size() + err_cyc.size()); miscompares++; end
    send_frame(8'h81, 1'b1, -1, 0, e0);
    idle(5);
    vectors++; if (ok_cyc.size() != 1) begin $display("FAIL mid_81_count: got %0d want 1", ok_cyc.size()); miscompares++; end
    if (ok_cyc.size() > 0) begin
      vectors++; if (ok_cyc[0] != e0 + LAT) begin $display("FAIL mid_81_cycle: got %0d want %0d", ok_cyc[0], e0 + LAT); miscompares++; end
    end
    vectors++; if (dat !== 8'h81) begin $display("FAIL mid_81_dat: got %h want 81", dat); miscompares++; end
  endtask

  task automatic test_gap_glitch();
    int e0, s, p;
    idle(60);
    clear_logs();
    send_frame(8'($urandom), 1'b1, -1, 0, e0);
    s = e0 + LAT;
    // Line low reaches the receiver two cycles after it is driven: 20 gap clocks counted.
    for (int k = 0; k < 100 && cyc < s + 18; k++) begin
      @(posedge clk);
      #1;
    end
    p = cyc;
    URXD = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    idle(80);
    vectors++; if (ok_cyc.size() != 1) begin $display("FAIL gapg_ok: got %0d want 1", ok_cyc.size()); miscompares++; end
    vectors++; if (gap_cyc.size() != 1) begin $display("FAIL gapg_count: got %0d want 1", gap_cyc.size()); miscompares++; end
    if (gap_cyc.size() > 0) begin
      vectors++; if (gap_cyc[0] != p + 3 + H + 2 + GAP * NT) begin $display("FAIL gapg_cycle: got %0d want %0d", gap_cyc[0], p + 3 + H + 2 + GAP * NT); miscompares++; end
    end
  endtask

  task automatic test_exclusive();
    int viol;
    viol = 0;
    for (int i = 1; i < all_cyc.size(); i++) begin
      if (all_cyc[i] - all_cyc[i - 1] < 2) viol++;
    end
    vectors++; if (viol != 0) begin $display("FAIL strobe_exclusive: got %0d violations want 0", viol); miscompares++; end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_gap_glitch();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/urxd_byte_rx.md
# urxd_byte_rx

UART 8N1 byte receiver that sits directly upstream of the CRC block receiver and drives its `URXD`-side byte stream. It takes the raw serial line, synchronizes it, validates the start bit, and samples each bit by 3-point majority vote. It delivers each byte with a one-clock strobe and flags framing errors. It also signals an inter-byte idle gap, which the block receiver uses to close a block.

## Interface
- `F_CLK`, 50_000_000: clock frequency in Hz.
- `BAUD`, 115200: line rate. NT = F_CLK/BAUD (integer division), H = NT/2. Legal only if NT ≥ 8.
- `GAP_BITS`, 20: idle bit-times that produce `ok_gap`.
- `clk` in 1: system clock; everything is on the rising edge.
- `res_n` in 1: asynchronous, active-low reset.
- `URXD` in 1: raw serial line; idles high.
- `en_rx_byte` out 1: high while a frame is in progress (any state other than IDLE/WAIT_HI).
- `ok_rx_byte` out 1: one-clock strobe; `dat` is valid in the same cycle.
- `dat` out 8: last good byte; held until the next good byte.
- `err_frm` out 1: one-clock strobe when the stop bit is sampled low.
- `ok_gap` out 1: one-clock strobe after GAP_BITS·NT idle clocks following a good byte.

## Operation
- **Synchronizer:** two flops, reset to 1, produce `rxs`. Nothing else reads `URXD`.
- **Majority vote:** each bit is sampled at cnt = H−1, H and H+1. The result is the majority of the three samples. The decision is taken at the edge where cnt = H+1.
- **Counters:**
  - `cnt` runs 0..NT−1 and wraps to 0.
  - `nbit` runs 0..9: 0 is the start bit, 1–8 are the data bits (LSB first), 9 is the stop bit.
  - `nbit` advances when `cnt` wraps.
- **States:**
  - IDLE: when `rxs`=0 → START, with cnt←0 and nbit←0.
  - START: if the decision is 1 (glitch) → IDLE, with no strobe. Otherwise continue, and at the wrap → DATA.
  - DATA: at each decision, shift the bit into the shift register at the MSB end (LSB first on the line). After the bit-8 wrap → STOP.
  - STOP, decision = 1: `dat`←shift register, pulse `ok_rx_byte`, go to IDLE at once. The rest of the stop bit is not waited out, so back-to-back frames are accepted.
  - STOP, decision = 0: pulse `err_frm`, leave `dat` unchanged, go to WAIT_HI.
  - WAIT_HI: stay until `rxs`=1, then → IDLE. This handles a break or stuck-low line, which gives exactly one `err_frm` per low episode.
- **Gap counter:**
  - Armed by `ok_rx_byte`.
  - Counts clocks while the state is IDLE and `rxs`=1.
  - Cleared, but kept armed, whenever `rxs`=0.
  - Reaching GAP_BITS·NT pulses `ok_gap` once and disarms.
  - `err_frm` also disarms it.
  - The counter is wide enough for GAP_BITS·NT; it must not wrap before terminal count.
- **Reset mid-frame:** asynchronous return to IDLE. Outputs and all counters return to reset values, and the gap counter is disarmed. A partial frame produces no strobe.

## Timing
- **Reset values:** `en_rx_byte`=0, `ok_rx_byte`=0, `dat`=8'h00, `err_frm`=0, `ok_gap`=0. Synchronizer flops = 1, state = IDLE.
- **Input latency:** a `URXD` edge reaches `rxs` 2 clocks later.
- **Reference edge E0:** the edge at which IDLE sees `rxs`=0. In clock j after E0, the counter values satisfy j = nbit·NT + cnt.
- **`en_rx_byte`:** high from clock 0 after E0 through the clock of the stop decision. Low again from clock 9·NT+H+2 on a good byte.
- **`ok_rx_byte` / `err_frm`:** high exactly in clock 9·NT+H+2 after E0.
- **Glitch rejection:** a false start returns to IDLE in clock H+2.
- **`ok_gap`:** high in the clock after the gap count reaches GAP_BITS·NT.
- **Strobe exclusivity:** `ok_rx_byte`, `err_frm` and `ok_gap` are mutually exclusive and are never high two clocks in a row.

## Test plan
All scenarios use F_CLK=16 and BAUD=1, so NT=16 and H=8, with GAP_BITS=2.
- **Byte 8'hA5 with a proper stop bit:** `ok_rx_byte` pulses once in clock 9·16+8+2=154 after E0, with `dat`=8'hA5. `err_frm` stays 0.
- **Bytes 8'h00 then 8'hFF back-to-back, no idle between frames:** two strobes, with `dat`=00 then FF. After 32 idle clocks a single `ok_gap` is seen.
- **Single-clock noise spikes:**
  - A 3-clock low pulse on the idle line gives no strobe, and `en_rx_byte` drops in clock 10.
  - A 1-clock spike inverting the centre sample of a data bit leaves `dat` correct.
- **Byte 8'h3C with stop bit 0, then line held low for 100 clocks:** exactly one `err_frm`, `dat` unchanged, no `ok_gap`. A following good 8'h5A is received normally.
- **`res_n` asserted at data bit 4, then the frame completes and a new 8'h81 is sent:** outputs are 0 immediately, there is no strobe for the broken frame, 8'h81 is received, and `dat`=8'h81.
- **Idle gap interrupted by a 3-clock glitch at gap clock 20:** the gap count restarts, and `ok_gap` fires 32 idle clocks after the glitch.
